// File: rtl/nc_uart_rx.sv
// nc_uart_rx -- 8N1 UART receiver feeding the NeuralChip command/load logic.
//
// Serial RXD is synchronized, framed (start / 8 data LSB-first / stop) and
// delivered into a single-entry valid/ready holding buffer. Framing errors
// and overruns are reported as one-cycle pulses. Single clock domain.
//
// Parameters:
//   CLKS_PER_BIT  core clocks per UART bit (>= 4)
//   CNT_W         baud counter width, must hold CLKS_PER_BIT-1
//
// Ports:
//   i_clk         core clock, rising edge
//   i_reset       synchronous active-high reset
//   i_rxd         asynchronous serial input, idles high
//   o_rx_data     received byte, valid while o_rx_valid
//   o_rx_valid    holding buffer full
//   i_rx_ready    consumer accept; transfer on o_rx_valid & i_rx_ready
//   o_frame_err   1-cycle pulse: stop bit sampled low
//   o_overrun     1-cycle pulse: byte completed while buffer full, not draining
//   o_busy        receiver FSM not idle
module nc_uart_rx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int CNT_W        = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rxd,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic       i_rx_ready,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
);

  // Start bit is re-checked half a bit in; data/stop are sampled one full
  // bit later each, so every sample lands near mid-bit.
  localparam logic [CNT_W-1:0] MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  // synchronizer
  logic r_sync1, r_sync2;
  logic w_rxs;

  // FSM / datapath state
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic [2:0]       r_idx,   w_idx_nxt;
  logic [7:0]       r_shift, w_shift_nxt;

  // holding buffer and pulses
  logic [7:0] r_data;
  logic       r_valid;
  logic       r_ferr, r_ovr;

  logic w_deliver;
  logic w_ferr;
  logic w_xfer;
  logic w_load;
  logic w_ovr;

  // Two flops take the metastability hit; only the second is ever looked at.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rxd;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxs = r_sync2;

  // Next-state / datapath decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_deliver   = 1'b0;
    w_ferr      = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (!w_rxs) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = '0;
        end
      end

      S_START: begin
        if (r_cnt == MID) begin
          w_cnt_nxt = '0;
          if (!w_rxs) begin
            w_state_nxt = S_DATA;
            w_idx_nxt   = 3'd0;
          end else begin
            // line went back high before mid-bit: a glitch, not a start
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (r_cnt == LAST) begin
          w_shift_nxt[r_idx] = w_rxs;
          w_cnt_nxt          = '0;
          w_idx_nxt          = r_idx + 3'd1;
          if (r_idx == 3'd7)
            w_state_nxt = S_STOP;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      S_STOP: begin
        if (r_cnt == LAST) begin
          w_cnt_nxt = '0;
          if (w_rxs) begin
            w_deliver   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = S_WAIT_HIGH;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      S_WAIT_HIGH: begin
        // a held-low line (break) must not be re-read as fresh start bits
        if (w_rxs)
          w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // A draining buffer counts as free, so drain+load on one edge keeps valid up.
  assign w_xfer = r_valid & i_rx_ready;
  assign w_load = w_deliver & (~r_valid | i_rx_ready);
  assign w_ovr  = w_deliver & r_valid & ~i_rx_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_shift <= 8'h00;
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_ferr  <= w_ferr;
      r_ovr   <= w_ovr;
      if (w_load) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_rx_data   = r_data;
  assign o_rx_valid  = r_valid;
  assign o_frame_err = r_ferr;
  assign o_overrun   = r_ovr;
  assign o_busy      = (r_state != S_IDLE);

endmodule
